// File: rtl/cpu_trace_pkg.sv
// Shared types and constants for the CPU trace recorder: FSM states,
// capture-mode encodings and the packed record width.
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } trace_state_e;

  localparam logic [1:0] MODE_ALL       = 2'b00;
  localparam logic [1:0] MODE_PCCHG     = 2'b01;
  localparam logic [1:0] MODE_DSP       = 2'b10;
  localparam logic [1:0] MODE_PC_OR_DSP = 2'b11;

  // Record layout, MSB first: {pc, alu_result, op_dsp, start_dsp, timestamp}
  function automatic int rec_width(input int xlen, input int ts_w);
    return 2 * xlen + 3 + ts_w;
  endfunction

endpackage

// File: rtl/cpu_trace_buffer_if.sv
// Readout stream of the trace buffer: one record per accepted transfer.
interface cpu_trace_buffer_if #(
  parameter int XLEN = 32,
  parameter int TS_W = 16
);
  // A record transfers on a rising edge where rd_valid and rd_ready are both 1.
  // While rd_valid=1 and rd_ready=0 the producer holds every rd_* field stable;
  // rd_valid never depends combinationally on rd_ready.
  logic            rd_valid;
  logic            rd_ready;
  logic [XLEN-1:0] rd_pc;
  logic [XLEN-1:0] rd_alu;
  logic [1:0]      rd_op;
  logic            rd_dsp;
  logic [TS_W-1:0] rd_ts;

  modport master (
    output rd_valid, rd_pc, rd_alu, rd_op, rd_dsp, rd_ts,
    input  rd_ready
  );

  modport slave (
    input  rd_valid, rd_pc, rd_alu, rd_op, rd_dsp, rd_ts,
    output rd_ready
  );
endinterface

// File: rtl/cpu_trace_buffer_ram.sv
// Record storage for the trace buffer: synchronous write, asynchronous read.
module trace_ring_ram #(
  parameter int W     = 83,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/cpu_trace_buffer.sv
// On-chip trace recorder for the CPU pipeline: qualified capture into a ring,
// PC-match trigger with post-trigger count, oldest-first drain over a stream.
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DEPTH     = 16,
  parameter int TS_W      = 16,
  parameter int POST_TRIG = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [XLEN-1:0]        pc,
  input  logic [XLEN-1:0]        alu_result,
  input  logic                   start_dsp,
  input  logic [1:0]             op_dsp,
  input  logic [1:0]             mode,
  input  logic                   arm,
  input  logic                   stop,
  input  logic                   trig_en,
  input  logic [XLEN-1:0]        trig_pc,
  cpu_trace_buffer_if.master     rd,
  output logic [1:0]             state,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = rec_width(XLEN, TS_W);

  trace_state_e    cur_state, nxt_state;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [TS_W-1:0] ts;
  logic [CW-1:0]   post_cnt, nxt_post;
  logic [XLEN-1:0] prev_pc;
  logic            prev_valid;
  logic            active, pc_chg, q, capture, pop, clear, trig_hit, full;
  logic [RW-1:0]   wdata, rdata;

  assign active   = (cur_state == ARMED) || (cur_state == POST);
  assign pc_chg   = !prev_valid || (pc != prev_pc);
  assign trig_hit = trig_en && (pc == trig_pc);
  assign full     = (count == CW'(DEPTH));

  always_comb begin
    q = 1'b0;
    case (mode)
      MODE_ALL:   q = 1'b1;
      MODE_PCCHG: q = pc_chg;
      MODE_DSP:   q = start_dsp;
      default:    q = pc_chg || start_dsp;
    endcase
  end

  // arm wins over everything, so a restart never also writes a record
  assign capture = active && q && !arm;
  assign pop     = (cur_state == DONE) && (count != '0) && rd.rd_ready && !arm;

  always_comb begin
    nxt_state = cur_state;
    nxt_post  = post_cnt;
    clear     = 1'b0;
    if (arm) begin
      nxt_state = ARMED;
      clear     = 1'b1;
    end else begin
      case (cur_state)
        ARMED: begin
          if (stop) begin
            nxt_state = DONE;
          end else if (trig_hit) begin
            if (POST_TRIG == 0) begin
              nxt_state = DONE;
            end else begin
              nxt_state = POST;
              nxt_post  = CW'(POST_TRIG);
            end
          end
        end
        POST: begin
          if (stop) begin
            nxt_state = DONE;
          end else if (capture) begin
            nxt_post = post_cnt - CW'(1);
            if (post_cnt == CW'(1)) nxt_state = DONE;
          end
        end
        DONE: begin
          if (count == '0) nxt_state = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_state  <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ts         <= '0;
      post_cnt   <= '0;
      overflow   <= 1'b0;
      prev_pc    <= '0;
      prev_valid <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      if (clear) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        ts         <= '0;
        post_cnt   <= '0;
        overflow   <= 1'b0;
        prev_valid <= 1'b0;
      end else begin
        post_cnt <= nxt_post;
        if (active) begin
          ts         <= ts + TS_W'(1);
          prev_pc    <= pc;
          prev_valid <= 1'b1;
        end
        // A full ring keeps the newest DEPTH records by dropping the oldest
        if (capture) begin
          wr_ptr <= wr_ptr + AW'(1);
          if (full) begin
            rd_ptr   <= rd_ptr + AW'(1);
            overflow <= 1'b1;
          end else begin
            count <= count + CW'(1);
          end
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
          count  <= count - CW'(1);
        end
      end
    end
  end

  assign wdata = {pc, alu_result, op_dsp, start_dsp, ts};

  trace_ring_ram #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (capture),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign rd.rd_valid = (cur_state == DONE) && (count != '0);
  assign rd.rd_pc    = rdata[RW-1 -: XLEN];
  assign rd.rd_alu   = rdata[RW-1-XLEN -: XLEN];
  assign rd.rd_op    = rdata[TS_W+2 -: 2];
  assign rd.rd_dsp   = rdata[TS_W];
  assign rd.rd_ts    = rdata[TS_W-1:0];
  assign state       = cur_state;
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Bench for cpu_trace_buffer: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed drained records.
module tb_cpu_trace_buffer;
  localparam int XLEN      = 32;
  localparam int DEPTH     = 16;
  localparam int TS_W      = 16;
  localparam int POST_TRIG = 8;
  localparam int REC_W     = 2 * XLEN + 3 + TS_W;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic [XLEN-1:0] pc = '0, alu_result = '0, trig_pc = '0;
  logic            start_dsp = 1'b0, arm = 1'b0, stop = 1'b0, trig_en = 1'b0;
  logic [1:0]      op_dsp = '0, mode = '0;
  logic [1:0]      state;
  logic [$clog2(DEPTH):0] count;
  logic            overflow;
  bit              cmp_en = 1'b0;

  always #5 clk = ~clk;

  cpu_trace_buffer_if #(.XLEN(XLEN), .TS_W(TS_W)) rd_if ();

  cpu_trace_buffer #(
    .XLEN(XLEN), .DEPTH(DEPTH), .TS_W(TS_W), .POST_TRIG(POST_TRIG)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pc         (pc),
    .alu_result (alu_result),
    .start_dsp  (start_dsp),
    .op_dsp     (op_dsp),
    .mode       (mode),
    .arm        (arm),
    .stop       (stop),
    .trig_en    (trig_en),
    .trig_pc    (trig_pc),
    .rd         (rd_if),
    .state      (state),
    .count      (count),
    .overflow   (overflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [REC_W-1:0] exp_q[$];
  int               m_state = 0;
  int               m_ts = 0;
  int               m_post = 0;
  bit               m_ovf = 1'b0;
  bit               m_first = 1'b1;
  logic [XLEN-1:0]  m_prev = '0;

  function automatic logic [REC_W-1:0] mk(input logic [XLEN-1:0] p, input logic [XLEN-1:0] a,
                                          input logic [1:0] o, input logic d, input int t);
    logic [TS_W-1:0] tt;
    tt = TS_W'(t);
    return {p, a, o, d, tt};
  endfunction

  always @(posedge clk or negedge reset_n) begin : model
    bit q, chg;
    if (!reset_n) begin
      exp_q.delete();
      m_state = 0; m_ts = 0; m_post = 0; m_ovf = 0; m_first = 1;
    end else if (arm) begin
      exp_q.delete();
      m_state = 1; m_ts = 0; m_post = 0; m_ovf = 0; m_first = 1;
    end else if (m_state == 1 || m_state == 2) begin
      chg = m_first || (pc != m_prev);
      case (mode)
        2'b00:   q = 1;
        2'b01:   q = chg;
        2'b10:   q = start_dsp;
        default: q = chg || start_dsp;
      endcase
      if (q) begin
        if (exp_q.size() == DEPTH) begin
          void'(exp_q.pop_front());
          m_ovf = 1;
        end
        exp_q.push_back(mk(pc, alu_result, op_dsp, start_dsp, m_ts));
      end
      if (stop) m_state = 3;
      else if (m_state == 1 && trig_en && pc == trig_pc) begin
        if (POST_TRIG == 0) m_state = 3;
        else begin m_state = 2; m_post = POST_TRIG; end
      end else if (m_state == 2 && q) begin
        m_post--;
        if (m_post == 0) m_state = 3;
      end
      m_prev  = pc;
      m_first = 0;
      m_ts    = (m_ts + 1) % (1 << TS_W);
    end else if (m_state == 3) begin
      if (exp_q.size() == 0) m_state = 0;
      else if (rd_if.rd_ready) void'(exp_q.pop_front());
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [REC_W-1:0] f;
    forever begin
      @(posedge clk);
      #1;
      if (cmp_en) begin
        chk("state", state, m_state);
        chk("count", count, exp_q.size());
        chk("overflow", overflow, m_ovf);
        chk("rd_valid", rd_if.rd_valid, (m_state == 3 && exp_q.size() != 0));
        if (m_state == 3 && exp_q.size() != 0) begin
          f = exp_q[0];
          chk("rd_pc", rd_if.rd_pc, f[REC_W-1 -: XLEN]);
          chk("rd_alu", rd_if.rd_alu, f[REC_W-1-XLEN -: XLEN]);
          chk("rd_op", rd_if.rd_op, f[TS_W+2 -: 2]);
          chk("rd_dsp", rd_if.rd_dsp, f[TS_W]);
          chk("rd_ts", rd_if.rd_ts, f[TS_W-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  logic [XLEN-1:0] got_pc[$];
  logic [TS_W-1:0] got_ts[$];
  logic [1:0]      got_op[$];
  logic            got_dsp[$];

  task automatic cyc(input logic [XLEN-1:0] p, input bit s = 0, input bit d = 0,
                     input logic [1:0] o = 2'b00);
    pc = p; alu_result = p ^ 32'hA5A5_0000; start_dsp = d; op_dsp = o; stop = s; arm = 0;
    @(negedge clk);
  endtask

  task automatic do_arm(input logic [1:0] m);
    mode = m; arm = 1; stop = 0;
    @(negedge clk);
  endtask

  task automatic drain(input bit toggle);
    logic [XLEN-1:0] hp, ha;
    logic [1:0]      ho;
    logic            hd;
    logic [TS_W-1:0] ht;
    bit              held;
    held = 0;
    got_pc.delete(); got_ts.delete(); got_op.delete(); got_dsp.delete();
    arm = 0; stop = 0; start_dsp = 0;
    for (int i = 0; i < 200; i++) begin
      if (held) begin
        chk("stall_pc", rd_if.rd_pc, hp);
        chk("stall_alu", rd_if.rd_alu, ha);
        chk("stall_op", rd_if.rd_op, ho);
        chk("stall_dsp", rd_if.rd_dsp, hd);
        chk("stall_ts", rd_if.rd_ts, ht);
      end
      if (state == 2'd0) break;
      rd_if.rd_ready = toggle ? (i % 2 == 1) : 1'b1;
      held = 0;
      if (rd_if.rd_valid) begin
        if (rd_if.rd_ready) begin
          got_pc.push_back(rd_if.rd_pc);
          got_ts.push_back(rd_if.rd_ts);
          got_op.push_back(rd_if.rd_op);
          got_dsp.push_back(rd_if.rd_dsp);
        end else begin
          held = 1;
          hp = rd_if.rd_pc; ha = rd_if.rd_alu; ho = rd_if.rd_op;
          hd = rd_if.rd_dsp; ht = rd_if.rd_ts;
        end
      end
      @(negedge clk);
    end
    rd_if.rd_ready = 0;
    chk("drain_idle", state, 2'd0);
  endtask

  task automatic pulse_reset(input string tag);
    reset_n = 0;
    #1;
    chk({tag, "_state"}, state, 2'd0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_rd_valid"}, rd_if.rd_valid, 0);
    chk({tag, "_overflow"}, overflow, 0);
    @(negedge clk);
    reset_n = 1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    rd_if.rd_ready = 0;
    #1 reset_n = 0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_state", state, 2'd0);
    chk("reset_count", count, 0);
    chk("reset_valid", rd_if.rd_valid, 0);
    chk("reset_ovf", overflow, 0);
    reset_n = 1;
    cmp_en = 1;
    @(negedge clk);

    // 1: every-cycle capture, stop-cycle sample included
    do_arm(2'b00);
    for (int i = 0; i < 5; i++) cyc(32'(i * 4));
    cyc(32'h14, 1);
    chk("t1_state", state, 2'd3);
    chk("t1_count", count, 6);
    drain(0);
    chk("t1_n", got_pc.size(), 6);
    for (int i = 0; i < got_pc.size() && i < 6; i++) begin
      chk("t1_pc", got_pc[i], 32'(i * 4));
      chk("t1_ts", got_ts[i], 16'(i));
    end

    // 2: overflow keeps newest 16 of 20
    do_arm(2'b00);
    for (int i = 0; i < 19; i++) cyc(32'(i * 4));
    cyc(32'd76, 1);
    chk("t2_count", count, 16);
    chk("t2_ovf", overflow, 1);
    drain(0);
    chk("t2_n", got_pc.size(), 16);
    if (got_pc.size() == 16) begin
      chk("t2_first_ts", got_ts[0], 16'd4);
      chk("t2_first_pc", got_pc[0], 32'd16);
      chk("t2_last_ts", got_ts[15], 16'd19);
      chk("t2_last_pc", got_pc[15], 32'd76);
    end

    // 3: pc-change qualifier
    do_arm(2'b01);
    cyc(32'h100); cyc(32'h100); cyc(32'h100);
    cyc(32'h104); cyc(32'h104); cyc(32'h108, 1);
    drain(0);
    chk("t3_n", got_pc.size(), 3);
    if (got_pc.size() == 3) begin
      chk("t3_pc0", got_pc[0], 32'h100); chk("t3_ts0", got_ts[0], 16'd0);
      chk("t3_pc1", got_pc[1], 32'h104); chk("t3_ts1", got_ts[1], 16'd3);
      chk("t3_pc2", got_pc[2], 32'h108); chk("t3_ts2", got_ts[2], 16'd5);
    end

    // 4: trigger at 0x40 plus 8 post-trigger records
    trig_en = 1; trig_pc = 32'h40;
    do_arm(2'b00);
    n = -1;
    for (int i = 0; i < 40; i++) begin
      cyc(32'(i * 4));
      if (state == 2'd3) begin n = i; break; end
    end
    chk("t4_done_at", n, 24);
    trig_en = 0;
    drain(0);
    chk("t4_n", got_pc.size(), 16);
    if (got_pc.size() == 16) begin
      chk("t4_first_pc", got_pc[0], 32'h24);
      chk("t4_last_pc", got_pc[15], 32'h60);
    end

    // 5: start_dsp qualifier, stalled drain
    do_arm(2'b10);
    for (int i = 0; i < 16; i++)
      cyc(32'(i * 4), i == 15, i == 8 || i == 12, (i == 8) ? 2'b01 : (i == 12) ? 2'b11 : 2'b00);
    drain(1);
    chk("t5_n", got_pc.size(), 2);
    if (got_pc.size() == 2) begin
      chk("t5_pc0", got_pc[0], 32'h20); chk("t5_op0", got_op[0], 2'b01);
      chk("t5_dsp0", got_dsp[0], 1);   chk("t5_ts0", got_ts[0], 16'd8);
      chk("t5_pc1", got_pc[1], 32'h30); chk("t5_op1", got_op[1], 2'b11);
      chk("t5_dsp1", got_dsp[1], 1);   chk("t5_ts1", got_ts[1], 16'd12);
    end

    // 6a: reset mid-POST
    trig_en = 1; trig_pc = 32'h10;
    do_arm(2'b00);
    for (int i = 0; i < 6; i++) cyc(32'(i * 4));
    chk("t6a_in_post", state, 2'd2);
    pulse_reset("t6a_rst");
    trig_en = 0;
    do_arm(2'b00);
    cyc(32'h200); cyc(32'h204, 1);
    drain(0);
    chk("t6a_n", got_pc.size(), 2);
    if (got_pc.size() == 2) begin
      chk("t6a_pc0", got_pc[0], 32'h200);
      chk("t6a_ts0", got_ts[0], 16'd0);
    end

    // 6b: reset mid-drain after overflow
    do_arm(2'b00);
    for (int i = 0; i < 19; i++) cyc(32'(i * 4));
    cyc(32'd76, 1);
    chk("t6b_ovf", overflow, 1);
    rd_if.rd_ready = 1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("t6b_count", count, 13);
    rd_if.rd_ready = 0;
    pulse_reset("t6b_rst");
    do_arm(2'b00);
    cyc(32'h300); cyc(32'h304, 1);
    drain(0);
    chk("t6b_n", got_pc.size(), 2);
    if (got_pc.size() == 2) begin
      chk("t6b_pc0", got_pc[0], 32'h300);
      chk("t6b_ts0", got_ts[0], 16'd0);
      chk("t6b_ts1", got_ts[1], 16'd1);
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end
endmodule
